rr_mux_sched: RTL and testbench
===============================

RR_MUX_SCHED -- requirements
Module: rr_mux_sched

Interface
REQ-001 Parameter: W, default 8, payload width in bits (W >= 2).
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset; assertion acts immediately, deassertion is synchronous to clk.
REQ-004 Port: req0_valid  input  1  requester 0 has a payload.
REQ-005 Port: req0_data  input  W  requester 0 payload.
REQ-006 Port: req0_ready  output  1  requester 0 payload accepted this cycle.
REQ-007 Port: req1_valid  input  1  requester 1 has a payload.
REQ-008 Port: req1_data  input  W  requester 1 payload.
REQ-009 Port: req1_ready  output  1  requester 1 payload accepted this cycle.
REQ-010 Port: out_valid  output  1  output register holds a result.
REQ-011 Port: out_data  output  W  result payload.
REQ-012 Port: out_src  output  1  source of out_data (0 = req0, 1 = req1).
REQ-013 Port: out_ready  input  1  consumer accepts the result this cycle.

Function
REQ-014 Transfer on any channel SHALL occur only when its valid and ready are both high in the same cycle.
REQ-015 Output register SHALL be loadable ("open") when out_valid is 0 or out_ready is 1.
REQ-016 At most one requester SHALL be granted per cycle, and only when the output register is open.
REQ-017 reqN_ready SHALL be combinational: open AND grant==N; it SHALL NOT depend on reqN_valid of the same requester.
REQ-018 Grant SHALL follow a 1-bit round-robin pointer `prio`: one valid requester is granted; if both are valid, requester `prio` is granted.
REQ-019 After each accepted transfer, `prio` SHALL become the index of the non-granted requester; with no transfer, `prio` SHALL hold.
REQ-020 Latency: a payload accepted in cycle N SHALL appear on out_valid/out_data/out_src in cycle N+1.
REQ-021 Throughput: one result per cycle SHALL be sustained while out_ready is 1.
REQ-022 Requester-0 payload SHALL pass through unchanged.
REQ-023 Requester-1 payload transform (see Configuration): ((d << 2) + 1), computed and truncated to W bits, with overflow discarded.
REQ-024 While out_valid is 1 and out_ready is 0, out_data and out_src SHALL hold stable and no requester SHALL be granted.
REQ-025 If out_ready is 1 and no requester is valid, out_valid SHALL drop to 0 on the next edge.
REQ-026 Two-state view: EMPTY (out_valid=0) goes to FULL on a grant. FULL stays FULL when a new grant coincides with drain, or when there is no drain. FULL goes to EMPTY on a drain without a grant.

Reset
REQ-027 While rst_n is 0: out_valid=0, out_data=0, out_src=0, prio=0; req0_ready and req1_ready SHALL be 0.
REQ-028 A reset asserted mid-operation SHALL discard any held result without handshake.
REQ-029 The first grant after reset, with both requesters valid, SHALL go to req0.

Configuration
REQ-030 Macro RR_MUX_SCHED_XFORM_EN defined: requester-1 payload SHALL be transformed per REQ-023.
REQ-031 Macro RR_MUX_SCHED_XFORM_EN undefined: requester-1 payload SHALL pass through unchanged; all timing and arbitration SHALL be identical.

Structure
REQ-032 Shared package rr_mux_sched_pkg SHALL hold the state enum (EMPTY, FULL), the source-index constants SRC_REQ0=0 and SRC_REQ1=1, and the transform shift amount (2) and offset (1).
REQ-033 One sub-module, rr_mux_sched_xform, SHALL implement the combinational W-bit transform; the top instantiates it on the req1 path.

Verification (W=8, XFORM_EN defined unless stated)
REQ-034 Only req1_valid, data 0x03, out_ready=1 -> req1_ready=1 in cycle 0; cycle 1: out_valid=1, out_data=0x0D, out_src=1.
REQ-035 req1 data 0x40 -> out_data=0x01 (overflow truncated); with XFORM_EN undefined -> out_data=0x40.
REQ-036 Both valid continuously, data 0xA0 and 0x01, out_ready=1 -> outputs alternate 0xA0(src0), 0x05(src1), 0xA0, 0x05; one result per cycle.
REQ-037 out_ready=0 while FULL with 0x55 from req0 -> both readies 0 and out_data stays 0x55 for 5 cycles; on out_ready=1 the next grant is accepted in the same cycle.
REQ-038 Assert rst_n=0 while FULL -> out_valid=0 immediately (before the next edge); after release with both valid, first output is src0.
REQ-039 Only req0 valid for 3 transfers, then both valid -> req1 is granted first (prio=1 after the req0 grants).

Source files
------------

// File: rtl/rr_mux_sched_pkg.sv
// Shared types and constants for the two-requester round-robin mux scheduler.
// Holds output-register state, source indices and the req1 transform shape.
package rr_mux_sched_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  localparam logic SRC_REQ0 = 1'b0;
  localparam logic SRC_REQ1 = 1'b1;

  localparam int XFORM_SHIFT  = 2;
  localparam int XFORM_OFFSET = 1;

endpackage

// File: rtl/rr_mux_sched_xform.sv
// Combinational req1 payload transform: (d << 2) + 1 truncated to W bits when
// RR_MUX_SCHED_XFORM_EN is defined, plain pass-through otherwise. Zero latency.
module rr_mux_sched_xform
  import rr_mux_sched_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

`ifdef RR_MUX_SCHED_XFORM_EN
  assign q_o = (d_i << XFORM_SHIFT) + W'(XFORM_OFFSET);
`else
  assign q_o = d_i;
`endif

endmodule

// File: rtl/rr_mux_sched.sv
// Two-requester round-robin mux into a single output register; 1-cycle latency.
// Readies drop while the output holds an undrained result; req1 path may be
// transformed (RR_MUX_SCHED_XFORM_EN).
module rr_mux_sched
  import rr_mux_sched_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_data,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_data,
  output logic         req1_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_src,
  input  logic         out_ready
);

  state_e         state_q, state_d;
  logic           prio_q, prio_d;
  logic [W-1:0]   data_q, data_d;
  logic           src_q, src_d;
  logic           open_w;
  logic           xfer0, xfer1;
  logic [W-1:0]   req1_xf;

  rr_mux_sched_xform #(.W(W)) u_xform (
    .d_i (req1_data),
    .q_o (req1_xf)
  );

  // Each ready looks only at the other requester's valid, so a requester
  // never sees its own valid reflected back into its ready.
  assign open_w     = rst_n & ((state_q == EMPTY) | out_ready);
  assign req0_ready = open_w & ((prio_q == SRC_REQ0) | ~req1_valid);
  assign req1_ready = open_w & ((prio_q == SRC_REQ1) | ~req0_valid);
  assign xfer0      = req0_valid & req0_ready;
  assign xfer1      = req1_valid & req1_ready;

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    data_d  = data_q;
    src_d   = src_q;
    if (xfer0 | xfer1) begin
      state_d = FULL;
      data_d  = xfer1 ? req1_xf : req0_data;
      src_d   = xfer1 ? SRC_REQ1 : SRC_REQ0;
      prio_d  = xfer1 ? SRC_REQ0 : SRC_REQ1;
    end else if ((state_q == FULL) && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      prio_q  <= SRC_REQ0;
      data_q  <= '0;
      src_q   <= SRC_REQ0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      data_q  <= data_d;
      src_q   <= src_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_src   = src_q;

endmodule

// File: tb/tb_rr_mux_sched.sv
// Directed bench for rr_mux_sched (W=8); expectations follow the build's
// RR_MUX_SCHED_XFORM_EN setting.
module tb_rr_mux_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid, out_ready;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready, out_valid, out_src;
  logic [7:0] out_data;

  int errors = 0;
  int checks = 0;

`ifdef RR_MUX_SCHED_XFORM_EN
  localparam logic [7:0] E03 = 8'h0D;
  localparam logic [7:0] E40 = 8'h01;
  localparam logic [7:0] E01 = 8'h05;
  localparam logic [7:0] E02 = 8'h09;
`else
  localparam logic [7:0] E03 = 8'h03;
  localparam logic [7:0] E40 = 8'h40;
  localparam logic [7:0] E01 = 8'h01;
  localparam logic [7:0] E02 = 8'h02;
`endif

  rr_mux_sched #(.W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic s);
    chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({tag, ".data"},  {24'd0, out_data},  {24'd0, d});
    chk({tag, ".src"},   {31'd0, out_src},   {31'd0, s});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data  = 8'hAA;
    req1_data  = 8'hBB;
    out_ready  = 1'b1;
    #3;
    chk_out("reset", 1'b0, 8'h00, 1'b0);
    chk("reset.rdy0", {31'd0, req0_ready}, 32'd0);
    chk("reset.rdy1", {31'd0, req1_ready}, 32'd0);
    tick();
    chk_out("reset_hold", 1'b0, 8'h00, 1'b0);

    // Single req1 payload 0x03
    @(negedge clk);
    rst_n      = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    req1_data  = 8'h03;
    #1;
    chk("r1only.rdy1", {31'd0, req1_ready}, 32'd1);
    tick();
    chk_out("r1_03", 1'b1, E03, 1'b1);

    // Overflow truncation on req1
    @(negedge clk);
    req1_data = 8'h40;
    tick();
    chk_out("r1_40", 1'b1, E40, 1'b1);

    // Both valid: strict alternation starting at req0 (prio back at 0)
    @(negedge clk);
    req0_valid = 1'b1;
    req0_data  = 8'hA0;
    req1_data  = 8'h01;
    tick();
    chk_out("alt0", 1'b1, 8'hA0, 1'b0);
    tick();
    chk_out("alt1", 1'b1, E01, 1'b1);
    tick();
    chk_out("alt2", 1'b1, 8'hA0, 1'b0);
    tick();
    chk_out("alt3", 1'b1, E01, 1'b1);

    // Load 0x55 from req0, then stall for 5 cycles
    @(negedge clk);
    req1_valid = 1'b0;
    req0_data  = 8'h55;
    tick();
    chk_out("stall_load", 1'b1, 8'h55, 1'b0);
    @(negedge clk);
    out_ready  = 1'b0;
    req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall.rdy0", {31'd0, req0_ready}, 32'd0);
      chk("stall.rdy1", {31'd0, req1_ready}, 32'd0);
      tick();
      chk_out("stall_hold", 1'b1, 8'h55, 1'b0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("unstall.rdy1", {31'd0, req1_ready}, 32'd1);
    chk("unstall.rdy0", {31'd0, req0_ready}, 32'd0);
    tick();
    chk_out("unstall", 1'b1, E01, 1'b1);

    // Drain with nothing valid
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    chk("drain.valid", {31'd0, out_valid}, 32'd0);

    // Mid-operation reset while FULL
    @(negedge clk);
    req0_valid = 1'b1;
    req0_data  = 8'h77;
    tick();
    chk_out("pre_rst", 1'b1, 8'h77, 1'b0);
    @(negedge clk);
    req0_valid = 1'b0;
    out_ready  = 1'b0;
    rst_n      = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    rst_n      = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data  = 8'h11;
    req1_data  = 8'h02;
    out_ready  = 1'b1;
    #1;
    chk("post_rst.rdy0", {31'd0, req0_ready}, 32'd1);
    chk("post_rst.rdy1", {31'd0, req1_ready}, 32'd0);
    tick();
    chk_out("post_rst", 1'b1, 8'h11, 1'b0);

    // Three req0-only transfers, then both valid -> req1 first
    @(negedge clk);
    req1_valid = 1'b0;
    req0_data  = 8'h21;
    tick();
    chk_out("r0_21", 1'b1, 8'h21, 1'b0);
    @(negedge clk);
    req0_data = 8'h22;
    tick();
    chk_out("r0_22", 1'b1, 8'h22, 1'b0);
    @(negedge clk);
    req0_data = 8'h23;
    tick();
    chk_out("r0_23", 1'b1, 8'h23, 1'b0);
    @(negedge clk);
    req1_valid = 1'b1;
    #1;
    chk("both.rdy1", {31'd0, req1_ready}, 32'd1);
    chk("both.rdy0", {31'd0, req0_ready}, 32'd0);
    tick();
    chk_out("both_first", 1'b1, E02, 1'b1);
    tick();
    chk_out("both_second", 1'b1, 8'h23, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
